// File: rtl/pts_pkg.sv
// Shared types, default parameters and lane helpers for the PE result serializer.
package pts_pkg;

    localparam int unsigned DEF_LANES     = 64;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_ADDR_W    = 15;
    localparam int unsigned DEF_ADDR_STEP = 2;
    localparam int unsigned DEF_MAX_POOL  = 4;
    localparam int unsigned LANE_MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pts_state_e;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [LANE_MAX_W-1:0] lane_max(
        input logic [LANE_MAX_W-1:0] a,
        input logic [LANE_MAX_W-1:0] b,
        input logic                  signed_mode,
        input int unsigned           width
    );
        logic [LANE_MAX_W-1:0] sign_s;
        logic [LANE_MAX_W-1:0] a_key;
        logic [LANE_MAX_W-1:0] b_key;
        sign_s = 64'd1 << (width - 32'd1);
        if (signed_mode) begin
            a_key = a ^ sign_s;
            b_key = b ^ sign_s;
        end else begin
            a_key = a;
            b_key = b;
        end
        if (a_key >= b_key) begin
            lane_max = a;
        end else begin
            lane_max = b;
        end
    endfunction

    function automatic int unsigned clamp_pool(
        input int unsigned cnt,
        input int unsigned max_pool
    );
        if (cnt == 32'd0) begin
            clamp_pool = 32'd1;
        end else if (cnt > max_pool) begin
            clamp_pool = max_pool;
        end else begin
            clamp_pool = cnt;
        end
    endfunction

endpackage

// File: rtl/lane_max_unit.sv
// One lane of the pool datapath: load or max-merge a beat, then optional ReLU.
module lane_max_unit
    import pts_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] cur_i,
    input  logic [DATA_W-1:0] beat_i,
    input  logic              load_i,
    input  logic              signed_i,
    input  logic              relu_i,
    output logic [DATA_W-1:0] res_o
);

    logic [LANE_MAX_W-1:0] max_s;
    logic [DATA_W-1:0]     pick_s;

    // ReLU is monotonic, so clamping every stored value equals clamping the final max.
    always_comb begin
        max_s = lane_max(LANE_MAX_W'(cur_i), LANE_MAX_W'(beat_i), signed_i, DATA_W);
        if (load_i) begin
            pick_s = beat_i;
        end else begin
            pick_s = max_s[DATA_W-1:0];
        end
        if (relu_i && signed_i && pick_s[DATA_W-1]) begin
            res_o = {DATA_W{1'b0}};
        end else begin
            res_o = pick_s;
        end
    end

endmodule

// File: rtl/pe_result_serializer.sv
// Max-pools a window of PE result beats lane-wise and writes the lanes out
// one word per Avalon-MM write at consecutive addresses.
module pe_result_serializer
    import pts_pkg::*;
#(
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned ADDR_STEP = DEF_ADDR_STEP,
    parameter int unsigned MAX_POOL  = DEF_MAX_POOL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]              in_addr,
    input  logic [$clog2(MAX_POOL+1)-1:0]  pool_cnt,
    input  logic                           signed_en,
    input  logic                           relu_en,
    output logic [ADDR_W-1:0]              avm_address,
    output logic [DATA_W-1:0]              avm_writedata,
    output logic                           avm_write,
    output logic                           avm_chipselect,
    output logic [DATA_W/8-1:0]            avm_byteenable,
    input  logic                           avm_waitrequest,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned CNT_W = $clog2(MAX_POOL + 1);
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BUF_W = LANES * DATA_W;

    pts_state_e        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  eff_q, eff_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              signed_q, signed_d;
    logic              relu_q, relu_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              beat_s;
    logic              load_s;
    logic              mode_signed_s;
    logic              mode_relu_s;
    logic [CNT_W-1:0]  in_eff_s;
    logic [CNT_W-1:0]  beat_inc_s;
    logic [BUF_W-1:0]  merged_s;
    logic [BUF_W-1:0]  buf_shift_s;

    assign beat_s        = in_valid && ready_q;
    assign load_s        = (state_q == IDLE);
    assign mode_signed_s = load_s ? signed_en : signed_q;
    assign mode_relu_s   = load_s ? relu_en : relu_q;
    assign in_eff_s      = CNT_W'(clamp_pool(32'(pool_cnt), MAX_POOL));
    assign beat_inc_s    = beat_q + CNT_W'(1);
    assign buf_shift_s   = buf_q >> DATA_W;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_max_unit #(
            .DATA_W (DATA_W)
        ) u_lane (
            .cur_i    (buf_q[k*DATA_W +: DATA_W]),
            .beat_i   (in_data[k*DATA_W +: DATA_W]),
            .load_i   (load_s),
            .signed_i (mode_signed_s),
            .relu_i   (mode_relu_s),
            .res_o    (merged_s[k*DATA_W +: DATA_W])
        );
    end

    // Next-state and output-register computation for the window FSM.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        addr_d    = addr_q;
        eff_d     = eff_q;
        beat_d    = beat_q;
        signed_d  = signed_q;
        relu_d    = relu_q;
        idx_d     = idx_q;
        write_d   = write_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (beat_s) begin
                    buf_d    = merged_s;
                    addr_d   = in_addr;
                    eff_d    = in_eff_s;
                    beat_d   = CNT_W'(1);
                    signed_d = signed_en;
                    relu_d   = relu_en;
                    idx_d    = {IDX_W{1'b0}};
                    if (in_eff_s == CNT_W'(1)) begin
                        state_d   = DRAIN;
                        write_d   = 1'b1;
                        address_d = in_addr;
                        wdata_d   = merged_s[DATA_W-1:0];
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    buf_d  = merged_s;
                    beat_d = beat_inc_s;
                    if (beat_inc_s == eff_q) begin
                        state_d   = DRAIN;
                        write_d   = 1'b1;
                        address_d = addr_q;
                        wdata_d   = merged_s[DATA_W-1:0];
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                // Buffer shifts down one lane per accepted word, so lane 0 is always next.
                if (write_q && !avm_waitrequest) begin
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        write_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = {IDX_W{1'b0}};
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        buf_d     = buf_shift_s;
                        wdata_d   = buf_shift_s[DATA_W-1:0];
                        address_d = address_q + ADDR_W'(ADDR_STEP);
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d != DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            buf_q     <= {BUF_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            eff_q     <= {CNT_W{1'b0}};
            beat_q    <= {CNT_W{1'b0}};
            signed_q  <= 1'b0;
            relu_q    <= 1'b0;
            idx_q     <= {IDX_W{1'b0}};
            write_q   <= 1'b0;
            address_q <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            eff_q     <= eff_d;
            beat_q    <= beat_d;
            signed_q  <= signed_d;
            relu_q    <= relu_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign in_ready       = ready_q;
    assign avm_address    = address_q;
    assign avm_writedata  = wdata_q;
    assign avm_write      = write_q;
    assign avm_chipselect = write_q;
    assign avm_byteenable = {(DATA_W/8){1'b1}};
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_pe_result_serializer.sv
// Randomised bench for pe_result_serializer with a lane-wise pooling reference model.
module tb_pe_result_serializer;

    localparam int LANES = 64;
    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int STEP  = 2;
    localparam int MAXP  = 4;
    localparam int CW    = $clog2(MAXP + 1);
    localparam int CAP   = LANES + 8;

    typedef logic [LANES*DW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    beat_t             in_data = '0;
    logic [AW-1:0]     in_addr = '0;
    logic [CW-1:0]     pool_cnt = '0;
    logic              signed_en = 1'b0;
    logic              relu_en = 1'b0;
    logic [AW-1:0]     avm_address;
    logic [DW-1:0]     avm_writedata;
    logic              avm_write;
    logic              avm_chipselect;
    logic [DW/8-1:0]   avm_byteenable;
    logic              avm_waitrequest = 1'b0;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t         beats[$];
    logic [AW-1:0] cap_a[CAP];
    logic [DW-1:0] cap_d[CAP];
    logic [AW-1:0] exp_a[LANES];
    logic [DW-1:0] exp_d[LANES];
    int cap_n = 0, done_n = 0, done_cyc = -1, last_cyc = -1, first_wr = -1;
    int stab_err = 0, sig_err = 0, forced = 0, stall_mode = 0, acc_cyc = -1;
    logic stalled_prev = 1'b0, rdy_at_done = 1'b0;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;

    pe_result_serializer #(
        .LANES(LANES), .DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(STEP), .MAX_POOL(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .pool_cnt(pool_cnt),
        .signed_en(signed_en), .relu_en(relu_en),
        .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_write(avm_write),
        .avm_chipselect(avm_chipselect), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: optional random stalls, with a forced 3-cycle stall on word 10.
    always @(posedge clk) begin
        #1;
        if (stall_mode == 2 && cap_n == 10 && forced < 3) begin
            avm_waitrequest = 1'b1;
            forced++;
        end else if (stall_mode != 0) begin
            avm_waitrequest = 1'($urandom_range(0, 1));
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    // Bus monitor: captures completed words, stability under stall, done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev && (!avm_write || avm_address !== prev_a || avm_writedata !== prev_d))
                stab_err++;
            if (avm_chipselect !== avm_write || avm_byteenable !== 2'b11) sig_err++;
            if (avm_write && first_wr < 0) first_wr = cyc;
            if (avm_write && !avm_waitrequest) begin
                if (cap_n < CAP) begin
                    cap_a[cap_n] = avm_address;
                    cap_d[cap_n] = avm_writedata;
                end
                cap_n++;
                last_cyc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                rdy_at_done = in_ready;
            end
            stalled_prev = avm_write && avm_waitrequest;
            prev_a = avm_address;
            prev_d = avm_writedata;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // Reference: per lane, max over the window's beats in integer arithmetic, then ReLU.
    function automatic void model(input int eff, input logic s, input logic r, input logic [AW-1:0] addr);
        for (int k = 0; k < LANES; k++) begin
            int best = 0;
            for (int b = 0; b < eff; b++) begin
                logic [DW-1:0] w;
                int v;
                w = beats[b][k*DW +: DW];
                v = s ? int'($signed(w)) : int'(w);
                if (b == 0 || v > best) best = v;
            end
            if (r && s && best < 0) best = 0;
            exp_d[k] = best[DW-1:0];
            exp_a[k] = AW'((int'(addr) + k * STEP) % (1 << AW));
        end
    endfunction

    function automatic int eff_of(input int pool);
        return (pool == 0) ? 1 : (pool > MAXP) ? MAXP : pool;
    endfunction

    task automatic rand_beats(input int n);
        beat_t b;
        beats.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < LANES; k++) b[k*DW +: DW] = DW'($urandom);
            beats.push_back(b);
        end
    endtask

    task automatic clear_mon();
        cap_n = 0; done_n = 0; done_cyc = -1; last_cyc = -1; first_wr = -1;
        stab_err = 0; sig_err = 0; forced = 0;
    endtask

    task automatic send_beats(input int pool, input logic [AW-1:0] addr, input logic s,
                              input logic r, input int n);
        for (int b = 0; b < n; b++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!in_ready && waited < 500) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL beat_ready: in_ready=%0b required 1 for beat %0d", in_ready, b);
            end
            in_data = beats[b]; in_addr = addr; pool_cnt = CW'(pool);
            signed_en = s; relu_en = r; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_done(output logic tmo);
        int n;
        n = 0;
        while (done_n == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tmo = (done_n == 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_ready, avm_write, avm_chipselect, busy, done} !== 5'b0 || avm_address !== '0 || avm_writedata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%0b wr=%0b cs=%0b busy=%0b done=%0b addr=%h data=%h required all 0",
                     in_ready, avm_write, avm_chipselect, busy, done, avm_address, avm_writedata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_passthrough();
        beat_t b;
        logic tmo;
        for (int k = 0; k < LANES; k++) b[k*DW +: DW] = DW'(k + 1);
        beats.delete(); beats.push_back(b);
        stall_mode = 0; clear_mon();
        model(1, 1'b0, 1'b0, 15'h0100);
        send_beats(1, 15'h0100, 1'b0, 1'b0, 1);
        wait_done(tmo);
        checks++;
        if (tmo || cap_n !== LANES || done_n !== 1) begin
            errors++;
            $display("FAIL pass_count: words=%0d dones=%0d timeout=%0b required %0d 1 0", cap_n, done_n, tmo, LANES);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL pass_word%0d: addr=%h data=%h required %h %h", k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (cap_a[63] !== 15'h017E || cap_d[63] !== 16'd64) begin
            errors++;
            $display("FAIL pass_last: addr=%h data=%h required 017e 0040", cap_a[63], cap_d[63]);
        end
        checks++;
        if (first_wr !== acc_cyc || last_cyc !== first_wr + LANES - 1 || done_cyc !== last_cyc + 1) begin
            errors++;
            $display("FAIL pass_timing: first=%0d last=%0d done=%0d required %0d %0d %0d",
                     first_wr, last_cyc, done_cyc, acc_cyc, acc_cyc + LANES - 1, acc_cyc + LANES);
        end
        checks++;
        if (!rdy_at_done || sig_err !== 0) begin
            errors++;
            $display("FAIL pass_ctrl: ready_at_done=%0b sig_err=%0d required 1 0", rdy_at_done, sig_err);
        end
    endtask

    task automatic test_unsigned_pool();
        logic tmo;
        logic [DW-1:0] l0[4] = '{16'd3, 16'd9, 16'd2, 16'd7};
        logic [DW-1:0] l63[4] = '{16'hFFFF, 16'd1, 16'd1, 16'd1};
        rand_beats(4);
        for (int i = 0; i < 4; i++) begin
            beats[i][0 +: DW] = l0[i];
            beats[i][63*DW +: DW] = l63[i];
        end
        stall_mode = 0; clear_mon();
        model(4, 1'b0, 1'b0, 15'h0200);
        send_beats(4, 15'h0200, 1'b0, 1'b0, 4);
        wait_done(tmo);
        checks++;
        if (tmo || cap_n !== LANES) begin
            errors++;
            $display("FAIL upool_count: words=%0d timeout=%0b required %0d 0", cap_n, tmo, LANES);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL upool_word%0d: addr=%h data=%h required %h %h", k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (cap_d[0] !== 16'd9 || cap_d[63] !== 16'hFFFF) begin
            errors++;
            $display("FAIL upool_fixed: w0=%h w63=%h required 0009 ffff", cap_d[0], cap_d[63]);
        end
    endtask

    task automatic test_signed_relu();
        logic tmo;
        for (int pass = 0; pass < 2; pass++) begin
            logic r;
            r = (pass == 0);
            rand_beats(2);
            beats[0][0 +: DW] = 16'hFFF0; beats[1][0 +: DW] = 16'hFFFE;
            beats[0][DW +: DW] = 16'h8000; beats[1][DW +: DW] = 16'h0005;
            stall_mode = 0; clear_mon();
            model(2, 1'b1, r, 15'h0400);
            send_beats(2, 15'h0400, 1'b1, r, 2);
            wait_done(tmo);
            checks++;
            if (tmo || cap_n !== LANES) begin
                errors++;
                $display("FAIL spool_count: relu=%0b words=%0d timeout=%0b required %0d 0", r, cap_n, tmo, LANES);
            end
            for (int k = 0; k < LANES; k++) begin
                checks++;
                if (cap_d[k] !== exp_d[k] || cap_a[k] !== exp_a[k]) begin
                    errors++;
                    $display("FAIL spool_word%0d relu=%0b: addr=%h data=%h required %h %h", k, r, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
                end
            end
            checks++;
            if (cap_d[0] !== (r ? 16'h0000 : 16'hFFFE) || cap_d[1] !== 16'h0005) begin
                errors++;
                $display("FAIL spool_fixed relu=%0b: w0=%h w1=%h required %h 0005", r, cap_d[0], cap_d[1], r ? 16'h0000 : 16'hFFFE);
            end
        end
    endtask

    task automatic test_stalls();
        logic tmo;
        int pool;
        logic s, r;
        pool = $urandom_range(1, MAXP); s = 1'($urandom); r = 1'($urandom);
        rand_beats(pool);
        stall_mode = 2; clear_mon();
        model(pool, s, r, 15'h1000);
        send_beats(pool, 15'h1000, s, r, pool);
        wait_done(tmo);
        stall_mode = 0;
        checks++;
        if (tmo || cap_n !== LANES || done_n !== 1 || forced !== 3) begin
            errors++;
            $display("FAIL stall_count: words=%0d dones=%0d forced=%0d timeout=%0b required %0d 1 3 0", cap_n, done_n, forced, tmo, LANES);
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL stall_stable: unstable_cycles=%0d required 0", stab_err);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL stall_word%0d: addr=%h data=%h required %h %h", k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_edge_configs();
        logic tmo;
        int pools[3] = '{0, 7, 1};
        logic [AW-1:0] addrs[3] = '{15'h0300, 15'h0500, 15'h7FFE};
        for (int t = 0; t < 3; t++) begin
            int eff;
            eff = eff_of(pools[t]);
            rand_beats(eff);
            stall_mode = 0; clear_mon();
            model(eff, 1'b1, 1'b0, addrs[t]);
            send_beats(pools[t], addrs[t], 1'b1, 1'b0, eff);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL edge%0d_drain: in_ready=%0b busy=%0b after %0d beats required 0 1", t, in_ready, busy, eff);
            end
            wait_done(tmo);
            checks++;
            if (tmo || cap_n !== LANES) begin
                errors++;
                $display("FAIL edge%0d_count: words=%0d timeout=%0b required %0d 0", t, cap_n, tmo, LANES);
            end
            for (int k = 0; k < LANES; k++) begin
                checks++;
                if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL edge%0d_word%0d: addr=%h data=%h required %h %h", t, k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
                end
            end
        end
        checks++;
        if (cap_a[1] !== 15'h0000 || cap_a[0] !== 15'h7FFE) begin
            errors++;
            $display("FAIL edge_wrap: a0=%h a1=%h required 7ffe 0000", cap_a[0], cap_a[1]);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic tmo;
        int n;
        rand_beats(1);
        stall_mode = 0; clear_mon();
        send_beats(1, 15'h0600, 1'b0, 1'b0, 1);
        n = 0;
        while (cap_n < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || cap_n < 20) begin
            errors++;
            $display("FAIL rst_abort: wr=%0b busy=%0b rdy=%0b words=%0d required 0 0 0 >=20", avm_write, busy, in_ready, cap_n);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_n !== 0 || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_nodone: dones=%0d wr=%0b required 0 0", done_n, avm_write);
        end
        rand_beats(2);
        clear_mon();
        model(2, 1'b1, 1'b1, 15'h0700);
        send_beats(2, 15'h0700, 1'b1, 1'b1, 2);
        wait_done(tmo);
        checks++;
        if (tmo || cap_n !== LANES || done_n !== 1) begin
            errors++;
            $display("FAIL rst_after_count: words=%0d dones=%0d timeout=%0b required %0d 1 0", cap_n, done_n, tmo, LANES);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL rst_after_word%0d: addr=%h data=%h required %h %h", k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic tmo;
        for (int w = 0; w < 4; w++) begin
            int pool, eff;
            logic s, r;
            logic [AW-1:0] addr;
            pool = $urandom_range(0, 7); eff = eff_of(pool);
            s = 1'($urandom); r = 1'($urandom); addr = AW'($urandom);
            rand_beats(eff);
            stall_mode = 1; clear_mon();
            model(eff, s, r, addr);
            send_beats(pool, addr, s, r, eff);
            wait_done(tmo);
            checks++;
            if (tmo || cap_n !== LANES || done_n !== 1 || stab_err !== 0) begin
                errors++;
                $display("FAIL b2b%0d_count: words=%0d dones=%0d unstable=%0d timeout=%0b required %0d 1 0 0",
                         w, cap_n, done_n, stab_err, tmo, LANES);
            end
            for (int k = 0; k < LANES; k++) begin
                checks++;
                if (cap_a[k] !== exp_a[k] || cap_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL b2b%0d_word%0d: addr=%h data=%h required %h %h", w, k, cap_a[k], cap_d[k], exp_a[k], exp_d[k]);
                end
            end
        end
        stall_mode = 0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_unsigned_pool();
        test_signed_relu();
        test_stalls();
        test_edge_configs();
        test_reset_mid_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_result_serializer.md
Name: pe_result_serializer

Overview:
- Parametrised successor of the PE-output parallel-to-serial writer.
- Accepts wide LANES×DATA_W result beats from the PE array and optionally max-pools a window of 1..MAX_POOL beats lane-wise (signed or unsigned, optional ReLU).
- Streams the pooled lanes, one DATA_W word per Avalon-MM write, to output memory at consecutive addresses.
- Sits between the PE array and the output-memory Avalon slave, under the layer controller.

Parameters:
- LANES, 64, number of DATA_W lanes per input beat.
- DATA_W, 16, lane/word width; also the Avalon writedata width (multiple of 8).
- ADDR_W, 15, Avalon address width.
- ADDR_STEP, 2, address increment per written word.
- MAX_POOL, 4, maximum beats per pooling window.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  PE beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*DATA_W  lanes; lane k = bits [k*DATA_W +: DATA_W]
- in_addr  in  ADDR_W  base write address; sampled on first beat of window
- pool_cnt  in  $clog2(MAX_POOL+1)  beats per window; sampled on first beat
- signed_en  in  1  signed lane compare/ReLU; sampled on first beat
- relu_en  in  1  clamp negative results to 0 (only meaningful with signed_en); sampled on first beat
- avm_address  out  ADDR_W  write address
- avm_writedata  out  DATA_W  write data
- avm_write  out  1  write request
- avm_chipselect  out  1  equals avm_write
- avm_byteenable  out  DATA_W/8  constant all ones
- avm_waitrequest  in  1  slave stall
- busy  out  1  high in ACCUM or DRAIN
- done  out  1  one-cycle pulse after last word of a window is accepted

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; in_ready=0 while in reset, 1 after.
  - avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0; busy=0, done=0.
  - Pool buffer and lane index cleared.
- Beat handshake: a beat is taken on a clock edge where in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in DRAIN.
- Window length: eff_cnt = pool_cnt clamped to [1, MAX_POOL] (0 → 1, >MAX_POOL → MAX_POOL).
- State machine:
  - IDLE: on a beat, load buf←in_data; latch addr←in_addr, eff_cnt, signed_en, relu_en; beat_cnt←1. Go DRAIN if eff_cnt==1, else ACCUM.
  - ACCUM: on a beat, buf[k]←max(buf[k], in_data[k]) for every lane, signed or unsigned per latched mode; beat_cnt++. Go DRAIN when the beat makes beat_cnt==eff_cnt. No beat → hold.
  - DRAIN:
    - avm_write=1 and avm_address=addr+idx*ADDR_STEP (mod 2^ADDR_W, wrap allowed).
    - avm_writedata=relu(buf[idx]), idx from 0 to LANES-1.
    - While avm_waitrequest=1, address/data/write stay stable. A word completes on an edge with avm_write && !avm_waitrequest; then idx++.
    - On completion of idx==LANES-1: avm_write←0 on that edge, done=1 for the next cycle, go IDLE.
- relu(x) = 0 if relu_en && signed_en && x<0, else x.
- Latency: beat accepted at edge N → first avm_write high in cycle N+1 (eff_cnt==1). With zero waitrequest, a window drains in exactly LANES cycles. The next beat can be accepted on the edge that completes the last word plus one cycle (IDLE).
- Outputs are registered; no combinational path from avm_waitrequest or in_valid to any output except in_ready (state-only).
- Reset mid-ACCUM or mid-DRAIN: abort immediately; partial window discarded, no done pulse.
- in_valid while in_ready=0: ignored; the PE must hold it.

Decomposition:
- Package pts_pkg:
  - state enum {IDLE, ACCUM, DRAIN}.
  - Default parameter localparams.
  - Function lane_max(a, b, signed_mode).
- Sub-module lane_max_unit: one lane's compare/select plus ReLU, instantiated LANES times by generate.

Test Plan:
1. Passthrough: pool_cnt=1, lane k = k+1, in_addr=0x0100, no stall → 64 writes, addresses 0x0100..0x017E step 2, data 1..64, done pulse one cycle after last word.
2. Unsigned pool: pool_cnt=4, four beats with lane0 = 3, 9, 2, 7 and lane63 = 0xFFFF, 1, 1, 1 → word0 = 9, word63 = 0xFFFF.
3. Signed pool + ReLU: signed_en=1, relu_en=1, pool_cnt=2.
   - lane0 = 0xFFF0, 0xFFFE → 0x0000.
   - lane1 = 0x8000, 0x0005 → 0x0005.
   - With relu_en=0, lane0 → 0xFFFE.
4. Stalls: waitrequest high for 3 cycles on word 10, random elsewhere → address/data stable while stalled, exactly 64 distinct writes, no dropped or duplicated word.
5. Edge configs:
   - pool_cnt=0 behaves as 1.
   - pool_cnt=7 (MAX_POOL=4) consumes exactly 4 beats.
   - in_addr=0x7FFE wraps word1 to address 0x0000.
6. Reset mid-DRAIN: rst_n low at word 20 → avm_write=0 asynchronously, no done pulse; after release, a new window drains from word 0 correctly.
